// File: rtl/wave_pkg.sv
// wave_pkg: mode and state encodings shared by the wave address generator
package wave_pkg;
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_LOOP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
endpackage

// File: rtl/wave_next_offset.sv
// wave_next_offset: combinational next offset/direction plus wrap and one-shot end flags
// ports: off_i/dir_i current position, step_i nonzero increment, last_i final offset L,
//        mode_i sweep mode; off_o/dir_o next position, wrap_o wrap/flip, end_o one-shot finished
module wave_next_offset import wave_pkg::*; #(
  parameter int LEN_W  = 10,
  parameter int STEP_W = 4
) (
  input  logic [LEN_W-1:0]  off_i,
  input  logic              dir_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [LEN_W-1:0]  last_i,
  input  logic [1:0]        mode_i,
  output logic [LEN_W-1:0]  off_o,
  output logic              dir_o,
  output logic              wrap_o,
  output logic              end_o
);
  logic [LEN_W:0] stp, sum;
  assign stp = (LEN_W+1)'(step_i);
  // one extra bit so offset+step past the top of the offset range cannot alias below L
  assign sum = {1'b0, off_i} + stp;
  always_comb begin
    off_o  = off_i;
    dir_o  = dir_i;
    wrap_o = 1'b0;
    end_o  = 1'b0;
    if (dir_i) begin
      dir_o  = {1'b0, off_i} > stp;
      off_o  = dir_o ? off_i - LEN_W'(step_i) : '0;
      wrap_o = !dir_o;
    end else if (sum <= {1'b0, last_i}) off_o = sum[LEN_W-1:0];
    else if (mode_i == MODE_ONESHOT) end_o = 1'b1;
    else if (mode_i == MODE_PINGPONG && off_i != last_i) off_o = last_i;
    else if (mode_i == MODE_PINGPONG) begin
      dir_o  = 1'b1;
      wrap_o = 1'b1;
      off_o  = {1'b0, last_i} > stp ? last_i - LEN_W'(step_i) : '0;
    end else begin
      off_o  = '0;
      wrap_o = 1'b1;
    end
  end
endmodule

// File: rtl/wave_addr_gen.sv
// wave_addr_gen: tick-driven address sweep over beg_addr+[0..L] in one-shot, loop or ping-pong mode
// ports: clk, reset (sync, active high), enable (low forces idle), start (latch config, begin),
//        tick (advance), beg_addr/last_off/step/mode config; out_addr, busy, done, wrap status
module wave_addr_gen import wave_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 10,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              tick,
  input  logic [ADDR_W-1:0] beg_addr,
  input  logic [LEN_W-1:0]  last_off,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              wrap
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] beg_q, beg_d, addr_q, addr_d;
  logic [LEN_W-1:0]  last_q, last_d, off_q, off_d, nx_off;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d, wrap_q, wrap_d, nx_dir, nx_wrap, nx_end;
  wave_next_offset #(.LEN_W(LEN_W), .STEP_W(STEP_W)) u_next (
    .off_i(off_q), .dir_i(dir_q), .step_i(step_q), .last_i(last_q), .mode_i(mode_q),
    .off_o(nx_off), .dir_o(nx_dir), .wrap_o(nx_wrap), .end_o(nx_end)
  );
  always_comb begin
    state_d = state_q;
    beg_d   = beg_q;
    last_d  = last_q;
    step_d  = step_q;
    mode_d  = mode_q;
    off_d   = off_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      off_d   = '0;
      dir_d   = 1'b0;
      addr_d  = '0;
    end else if (start) begin
      state_d = ST_RUN;
      beg_d   = beg_addr;
      last_d  = last_off;
      step_d  = step == '0 ? STEP_W'(1) : step;
      mode_d  = mode == 2'b11 ? MODE_LOOP : mode;
      off_d   = '0;
      dir_d   = 1'b0;
      addr_d  = beg_addr;
    end else if (state_q == ST_RUN && tick) begin
      state_d = nx_end ? ST_DONE : ST_RUN;
      off_d   = nx_off;
      dir_d   = nx_dir;
      wrap_d  = nx_wrap;
      addr_d  = beg_q + ADDR_W'(nx_off);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beg_q   <= '0;
      last_q  <= '0;
      step_q  <= '0;
      mode_q  <= '0;
      off_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beg_q   <= beg_d;
      last_q  <= last_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
    end
  end
  assign out_addr = addr_q;
  assign busy     = state_q == ST_RUN;
  assign done     = state_q == ST_DONE;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_wave_addr_gen.sv
// tb_wave_addr_gen: random and directed stimulus checked against a behavioural sweep model
module tb_wave_addr_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, start = 1'b0, tick = 1'b0;
  logic [15:0] beg_addr = '0;
  logic [9:0]  last_off = '0;
  logic [3:0]  step = '0;
  logic [1:0]  mode = '0;
  logic [15:0] out_addr;
  logic        busy, done, wrap;
  int tests = 0, fails = 0;
  bit live = 0;
  int m_st = 0, m_off = 0, m_dir = 0, m_addr = 0, m_wrap = 0;
  int m_beg = 0, m_len = 0, m_step = 0, m_mode = 0;

  wave_addr_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .tick(tick),
    .beg_addr(beg_addr), .last_off(last_off), .step(step), .mode(mode),
    .out_addr(out_addr), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: m_st 0 idle, 1 running, 2 finished; offset walks the spec rules in plain integers
  always @(posedge clk) begin
    live = 1;
    m_wrap = 0;
    if (reset) begin
      m_st = 0; m_off = 0; m_dir = 0; m_addr = 0;
      m_beg = 0; m_len = 0; m_step = 0; m_mode = 0;
    end else if (!enable) begin
      m_st = 0; m_off = 0; m_dir = 0; m_addr = 0;
    end else if (start) begin
      m_beg = int'(beg_addr); m_len = int'(last_off);
      m_step = step == 0 ? 1 : int'(step);
      m_mode = mode == 3 ? 1 : int'(mode);
      m_st = 1; m_off = 0; m_dir = 0; m_addr = m_beg;
    end else if (m_st == 1 && tick) begin
      if (m_dir == 1) begin
        if (m_off > m_step) m_off -= m_step;
        else begin m_off = 0; m_dir = 0; m_wrap = 1; end
      end else if (m_off + m_step <= m_len) m_off += m_step;
      else if (m_mode == 0) m_st = 2;
      else if (m_mode == 1) begin m_off = 0; m_wrap = 1; end
      else if (m_off != m_len) m_off = m_len;
      else begin
        m_dir = 1; m_wrap = 1;
        m_off = m_len > m_step ? m_len - m_step : 0;
      end
      m_addr = (m_beg + m_off) % 65536;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("addr", int'(out_addr), m_addr);
      chk("busy", int'(busy), int'(m_st == 1));
      chk("done", int'(done), int'(m_st == 2));
      chk("wrap", int'(wrap), m_wrap);
    end
  end

  task automatic cyc(input logic r, input logic e, input logic s, input logic t);
    reset = r; enable = e; start = s; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int b, input int l, input int s, input int m);
    beg_addr = 16'(b); last_off = 10'(l); step = 4'(s); mode = 2'(m);
  endtask

  // literal expectation pinned against both the DUT and the model
  task automatic lit(input string nm, input int a, input int b, input int d, input int w);
    chk({nm, "_addr"}, int'(out_addr), a);
    chk({nm, "_busy"}, int'(busy), b);
    chk({nm, "_done"}, int'(done), d);
    chk({nm, "_wrap"}, int'(wrap), w);
    chk({nm, "_model"}, m_addr, a);
  endtask

  initial begin
    int a36[7] = '{'h1000, 'h1001, 'h1002, 'h1003, 'h1004, 'h1005, 'h1005};
    int a38[6] = '{0, 2, 4, 2, 0, 2};
    int w38[6] = '{0, 0, 0, 1, 1, 0};
    int a39[5] = '{'hFFFE, 'hFFFF, 0, 1, 'hFFFE};
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    lit("reset", 0, 0, 0, 0);
    cfg('h1000, 5, 1, 0);
    cyc(0, 0, 1, 0);
    lit("start_no_en", 0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    lit("os_0", a36[0], 1, 0, 0);
    cfg('h4444, 1, 7, 1);
    for (int i = 1; i < 7; i++) begin
      cyc(0, 1, 0, 1);
      lit("os_n", a36[i], int'(i < 6), int'(i == 6), 0);
    end
    cyc(0, 1, 0, 1);
    lit("os_hold", 'h1005, 0, 1, 0);
    cfg('h0200, 7, 3, 1);
    cyc(0, 1, 1, 0);
    lit("loop_0", 'h200, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("loop_1", 'h203, 1, 0, 0);
    cyc(0, 1, 0, 0); lit("loop_hold", 'h203, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("loop_2", 'h206, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("loop_wrap", 'h200, 1, 0, 1);
    cyc(0, 1, 0, 1); lit("loop_3", 'h203, 1, 0, 0);
    cyc(0, 0, 0, 1); lit("en_low", 0, 0, 0, 0);
    cyc(0, 1, 1, 1); lit("restart_tick", 'h200, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("restart_adv", 'h203, 1, 0, 0);
    cfg(0, 4, 2, 2);
    cyc(0, 1, 1, 0);
    lit("pp_0", a38[0], 1, 0, w38[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(0, 1, 0, 1);
      lit("pp_n", a38[i], 1, 0, w38[i]);
    end
    cfg('hFFFE, 3, 1, 3);
    cyc(0, 1, 1, 0);
    lit("aw_0", a39[0], 1, 0, 0);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 1, 0, 1);
      lit("aw_n", a39[i], 1, 0, int'(i == 4));
    end
    cyc(1, 1, 0, 1);
    lit("reset_run", 0, 0, 0, 0);
    cfg('h0300, 2, 0, 1);
    cyc(0, 1, 1, 0); lit("s0_0", 'h300, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("s0_1", 'h301, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("s0_2", 'h302, 1, 0, 0);
    cfg('h0500, 0, 3, 2);
    cyc(0, 1, 1, 0); lit("l0pp_0", 'h500, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("l0pp_1", 'h500, 1, 0, 1);
    cyc(0, 1, 0, 1); lit("l0pp_2", 'h500, 1, 0, 1);
    cfg('h0500, 0, 3, 0);
    cyc(0, 1, 1, 0); lit("l0os_0", 'h500, 1, 0, 0);
    cyc(0, 1, 0, 1); lit("l0os_1", 'h500, 0, 1, 0);
    for (int i = 0; i < 6000; i++) begin
      beg_addr = $urandom_range(0, 3) == 0 ? 16'($urandom_range(16'hFFC0, 16'hFFFF)) : 16'($urandom);
      last_off = $urandom_range(0, 7) == 0 ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 12));
      step = 4'($urandom);
      mode = 2'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
